// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier among N_REQ requesters; results are
// routed back through an in-order tag FIFO. Optional counters under FP_MUL_ARB_STATS_EN.
module fp_mul_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][31:0] req_dataa,
  input  logic [N_REQ-1:0][31:0] req_datab,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   mul_snk_valid,
  output logic [31:0]            mul_snk_dataa,
  output logic [31:0]            mul_snk_datab,
  input  logic                   mul_snk_ready,
  input  logic                   mul_src_valid,
  input  logic [31:0]            mul_src_data,
  output logic                   mul_src_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [31:0]            rsp_data,
  input  logic [N_REQ-1:0]       rsp_ready
`ifdef FP_MUL_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][15:0] stat_issue_cnt,
  output logic [15:0]            stat_stall_cnt
`endif
);

  localparam int GW = $clog2(N_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [GW:0]   N_REQ_W   = (GW+1)'(N_REQ);
  localparam logic [GW-1:0] LAST_REQ  = GW'(N_REQ - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(TAG_DEPTH);

  logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] tag_count_reg, tag_count_next;
  logic [GW-1:0] tag_mem [TAG_DEPTH];

  logic [N_REQ-1:0][GW-1:0] cand_idx;
  logic [N_REQ-1:0]         cand_hit;
  logic [GW-1:0]            gnt;
  logic                     any_req;
  logic                     credit_ok;
  logic                     issue_en;
  logic                     fire;
  logic [GW-1:0]            tag_head;
  logic                     fifo_empty;
  logic                     src_en;
  logic                     pop;

  // Candidate at offset gi is rr_ptr+gi folded back into 0..N_REQ-1.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [GW:0] sum;
    assign sum          = {1'b0, rr_ptr_reg} + (GW+1)'(gi);
    assign cand_idx[gi] = (sum >= N_REQ_W) ? GW'(sum - N_REQ_W) : sum[GW-1:0];
    assign cand_hit[gi] = req_valid[cand_idx[gi]];
  end

  always_comb begin
    gnt = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) gnt = cand_idx[k];
    end
  end

  assign any_req   = |req_valid;
  assign credit_ok = (tag_count_reg < DEPTH_CNT);
  assign issue_en  = !rst && credit_ok;

  assign mul_snk_valid = any_req && issue_en;
  assign mul_snk_dataa = req_dataa[gnt];
  assign mul_snk_datab = req_datab[gnt];
  assign fire          = mul_snk_valid && mul_snk_ready;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = issue_en && mul_snk_ready && (gnt == GW'(gi));
  end

  // Return path: the FIFO head names the owner of the result currently at the multiplier output.
  assign tag_head   = tag_mem[rd_ptr_reg];
  assign fifo_empty = (tag_count_reg == '0);
  assign src_en     = !rst && !fifo_empty;

  assign mul_src_ready = src_en && rsp_ready[tag_head];
  assign rsp_data      = mul_src_data;
  assign pop           = mul_src_valid && mul_src_ready;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = src_en && mul_src_valid && (tag_head == GW'(gi));
  end

  always_comb begin
    rr_ptr_next    = rr_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    tag_count_next = tag_count_reg;
    if (fire) begin
      rr_ptr_next = (gnt == LAST_REQ) ? '0 : gnt + GW'(1);
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (pop) rd_ptr_next = rd_ptr_reg + PW'(1);
    case ({fire, pop})
      2'b10:   tag_count_next = tag_count_reg + CW'(1);
      2'b01:   tag_count_next = tag_count_reg - CW'(1);
      default: tag_count_next = tag_count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      tag_count_reg <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      tag_count_reg <= tag_count_next;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge clk) begin
    if (fire) tag_mem[wr_ptr_reg] <= gnt;
  end

`ifdef FP_MUL_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
    logic [15:0] issue_cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        issue_cnt_reg <= '0;
      end else if (fire && (gnt == GW'(gi))) begin
        issue_cnt_reg <= issue_cnt_reg + 16'd1;
      end
    end
    assign stat_issue_cnt[gi] = issue_cnt_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (any_req && !credit_ok && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stat_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a latency-11 multiplier model feeding an output queue.
module tb_fp_mul_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0][31:0] req_dataa = '0;
  logic [N-1:0][31:0] req_datab = '0;
  logic [N-1:0]      req_ready;
  logic              mul_snk_valid;
  logic [31:0]       mul_snk_dataa, mul_snk_datab;
  logic              mul_snk_ready = 1'b1;
  logic              mul_src_valid = 1'b0;
  logic [31:0]       mul_src_data = '0;
  logic              mul_src_ready;
  logic [N-1:0]      rsp_valid;
  logic [31:0]       rsp_data;
  logic [N-1:0]      rsp_ready = '0;
`ifdef FP_MUL_ARB_STATS_EN
  logic [N-1:0][15:0] stat_issue_cnt;
  logic [15:0]        stat_stall_cnt;
`endif

  fp_mul_arbiter #(.N_REQ(N), .TAG_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dataa(req_dataa), .req_datab(req_datab), .req_ready(req_ready),
    .mul_snk_valid(mul_snk_valid), .mul_snk_dataa(mul_snk_dataa), .mul_snk_datab(mul_snk_datab),
    .mul_snk_ready(mul_snk_ready),
    .mul_src_valid(mul_src_valid), .mul_src_data(mul_src_data), .mul_src_ready(mul_src_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
`ifdef FP_MUL_ARB_STATS_EN
    , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000, F6 = 32'h40C00000, F8 = 32'h41000000;
  logic [31:0] fval [4] = '{F1, F2, F3, F4};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact for normal operands whose product fits the mantissa (truncating model).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      return {a[31] ^ b[31], e[7:0], m[46:24]};
    end
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  // Multiplier model: 10 pipeline stages plus an output queue give 11 cycles fire-to-result.
  logic [9:0]       pv = '0;
  logic [9:0][31:0] pd = '0;
  logic [31:0]      mq [$];

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      mq.delete();
      mul_src_valid <= 1'b0;
      mul_src_data  <= '0;
    end else begin
      if (mul_src_valid && mul_src_ready) void'(mq.pop_front());
      if (pv[9]) mq.push_back(pd[9]);
      pv <= {pv[8:0], mul_snk_valid && mul_snk_ready};
      pd <= {pd[8:0], fmul(mul_snk_dataa, mul_snk_datab)};
      mul_src_valid <= (mq.size() != 0);
      mul_src_data  <= (mq.size() != 0) ? mq[0] : 32'h0;
    end
  end

  int          rsp_idx_q [$];
  logic [31:0] rsp_dat_q [$];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst && rsp_valid[i] && rsp_ready[i]) begin
        rsp_idx_q.push_back(i);
        rsp_dat_q.push_back(rsp_data);
        $display("[TB] rsp req=%0d data=0x%08h t=%0t", i, rsp_data, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rsp();
    rsp_idx_q.delete();
    rsp_dat_q.delete();
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int c = 0; c < budget && rsp_idx_q.size() < n; c++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] fair_exp [8] = '{F1, F2, F3, F4, F2, F4, F6, F8};
  logic [31:0] bp_exp   [4] = '{F2, F4, F6, F8};
  int fired [4];
  int fires, lat;
  bit got;

  initial begin
    // Reset state, with every input trying to provoke activity.
    req_valid = '1;
    rsp_ready = '1;
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'h0);
    check_eq("rst_snk_valid", 64'(mul_snk_valid), 64'h0);
    check_eq("rst_src_ready", 64'(mul_src_ready), 64'h0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_eq("rst_tag_count", 64'(dut.tag_count_reg), 64'h0);
    check_eq("rst_rr_ptr", 64'(dut.rr_ptr_reg), 64'h0);
    tick();

    // Round-robin fairness: each requester has two operations.
    clear_rsp();
    for (int i = 0; i < N; i++) fired[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (fired[i] < 2);
        req_dataa[i] = fval[i];
        req_datab[i] = (fired[i] == 0) ? F1 : F2;
      end
      @(negedge clk);
      check_eq($sformatf("fair_gnt%0d", c), 64'(req_ready & req_valid), 64'(4'b0001 << (c % 4)));
      for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) fired[i]++;
      tick();
    end
    req_valid = '0;
    wait_rsp(8, 40);
    check_eq("fair_rsp_cnt", 64'(rsp_idx_q.size()), 64'd8);
    for (int p = 0; p < 8 && p < rsp_idx_q.size(); p++) begin
      check_eq($sformatf("fair_idx%0d", p), 64'(rsp_idx_q[p]), 64'(p % 4));
      check_eq($sformatf("fair_dat%0d", p), 64'(rsp_dat_q[p]), 64'(fair_exp[p]));
    end
`ifdef FP_MUL_ARB_STATS_EN
    for (int i = 0; i < N; i++) check_eq($sformatf("stat_issue%0d", i), 64'(stat_issue_cnt[i]), 64'd2);
`endif

    // Single requester 2: 3.0 x 2.0, result exactly 11 cycles after fire.
    clear_rsp();
    req_valid = 4'b0100;
    req_dataa[2] = F3;
    req_datab[2] = F2;
    @(negedge clk);
    check_eq("single_ready", 64'(req_ready), 64'b0100);
    check_eq("single_snk_a", 64'(mul_snk_dataa), 64'(F3));
    tick();
    req_valid = '0;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        got = 1'b1;
        lat = c;
        check_eq("single_rsp_valid", 64'(rsp_valid), 64'b0100);
        check_eq("single_rsp_data", 64'(rsp_data), 64'(F6));
      end
      tick();
    end
    check_eq("single_latency", 64'(lat), 64'd11);

    // Credit exhaustion: rsp_ready low, rr_ptr now 3, exactly 16 fires then stall.
    clear_rsp();
    rsp_ready = '0;
    fires = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
        req_dataa[i] = fval[i];
        req_datab[i] = F1;
      end
      @(negedge clk);
      if (c == 19) begin
        check_eq("credit_snk_valid", 64'(mul_snk_valid), 64'h0);
        check_eq("credit_req_ready", 64'(req_ready), 64'h0);
        check_eq("credit_head_rsp", 64'(rsp_valid), 64'b1000);
        check_eq("credit_src_ready", 64'(mul_src_ready), 64'h0);
      end
      if ((req_ready & req_valid) != '0) fires++;
      tick();
    end
    check_eq("credit_fires", 64'(fires), 64'd16);
    rsp_ready = '1;
    @(negedge clk);
    check_eq("credit_pop", 64'(mul_src_ready), 64'h1);
    check_eq("credit_no_issue", 64'(req_ready), 64'h0);
    tick();
    @(negedge clk);
    check_eq("credit_resume", 64'(req_ready & req_valid), 64'b1000);
    tick();
    req_valid = '0;
    wait_rsp(17, 60);
    check_eq("credit_rsp_cnt", 64'(rsp_idx_q.size()), 64'd17);
    for (int p = 0; p < 17 && p < rsp_idx_q.size(); p++) begin
      check_eq($sformatf("credit_idx%0d", p), 64'(rsp_idx_q[p]), 64'((3 + p) % 4));
      check_eq($sformatf("credit_dat%0d", p), 64'(rsp_dat_q[p]), 64'(fval[(3 + p) % 4]));
    end
    check_eq("credit_drained", 64'(dut.tag_count_reg), 64'h0);
`ifdef FP_MUL_ARB_STATS_EN
    check_eq("stat_stall", 64'(stat_stall_cnt), 64'd5);
`endif

    // Response backpressure: head owner (requester 0) holds off for 5 cycles.
    clear_rsp();
    rsp_ready = 4'b1110;
    for (int i = 0; i < N; i++) begin
      fired[i] = 0;
      req_dataa[i] = fval[i];
      req_datab[i] = F2;
    end
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) req_valid[i] = (fired[i] == 0);
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) fired[i]++;
      tick();
    end
    req_valid = '0;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) got = 1'b1;
      else tick();
    end
    check_eq("bp_arrived", 64'(got), 64'h1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check_eq($sformatf("bp_src_ready%0d", k), 64'(mul_src_ready), 64'h0);
      check_eq($sformatf("bp_rsp_valid%0d", k), 64'(rsp_valid), 64'b0001);
      tick();
    end
    check_eq("bp_held", 64'(rsp_idx_q.size()), 64'd0);
    rsp_ready = '1;
    wait_rsp(4, 30);
    check_eq("bp_rsp_cnt", 64'(rsp_idx_q.size()), 64'd4);
    for (int p = 0; p < 4 && p < rsp_idx_q.size(); p++) begin
      check_eq($sformatf("bp_idx%0d", p), 64'(rsp_idx_q[p]), 64'(p));
      check_eq($sformatf("bp_dat%0d", p), 64'(rsp_dat_q[p]), 64'(bp_exp[p]));
    end
    wait_rsp(5, 20);

    // Reset with 6 operations outstanding.
    clear_rsp();
    for (int c = 0; c < 6; c++) begin
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
        req_dataa[i] = fval[i];
        req_datab[i] = F1;
      end
      @(negedge clk);
      tick();
    end
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_outstanding", 64'(dut.tag_count_reg), 64'd6);
    check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check_eq("mid_rst_src_ready", 64'(mul_src_ready), 64'h0);
    tick();
    rst = 1'b0;
    clear_rsp();
    req_valid = 4'b0010;
    req_dataa[1] = F3;
    req_datab[1] = F2;
    @(negedge clk);
    check_eq("mid_tag_count", 64'(dut.tag_count_reg), 64'h0);
    check_eq("mid_rr_ptr", 64'(dut.rr_ptr_reg), 64'h0);
    check_eq("mid_rsp_valid", 64'(rsp_valid), 64'h0);
    check_eq("mid_req_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    repeat (20) tick();
    check_eq("mid_rsp_cnt", 64'(rsp_idx_q.size()), 64'd1);
    if (rsp_idx_q.size() != 0) begin
      check_eq("mid_rsp_idx", 64'(rsp_idx_q[0]), 64'd1);
      check_eq("mid_rsp_dat", 64'(rsp_dat_q[0]), 64'(F6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
